// File: rtl/car_warning_pkg.sv
// Shared types and constants for the car door/seat-belt warning controller.
// One-hot FSM encoding, reset values of the debounced switches, and the warning equation.
package car_warning_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_CHIME_ON  = 4'b0010,
    ST_CHIME_OFF = 4'b0100,
    ST_MUTED     = 4'b1000
  } state_t;

  // Bit positions of the one-hot states that drive outputs directly
  localparam int IDX_CHIME_ON = 1;
  localparam int IDX_MUTED    = 3;

  // Debounced switch values at reset: door closed, belt fastened, ignition off
  localparam logic DOOR_RST = 1'b1;
  localparam logic BELT_RST = 1'b1;
  localparam logic IGN_RST  = 1'b0;

  function automatic logic warn_eq(input logic door, input logic ign, input logic belt);
    return ign & (~door | ~belt);
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Single-input debouncer: a new raw level is accepted after DEBOUNCE_CYC
// consecutive samples of that level; shorter excursions are discarded.
module input_debounce #(
  parameter int   DEBOUNCE_CYC = 4,
  parameter int   CNT_W        = 8,
  parameter logic RST_VAL      = 1'b0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic RawIn,
  output logic FiltOut
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             filt_r;

  // Count consecutive disagreeing samples; accept the new level on the last one
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_r  <= {CNT_W{1'b0}};
      filt_r <= RST_VAL;
    end else if (RawIn == filt_r) begin
      cnt_r  <= {CNT_W{1'b0}};
      filt_r <= filt_r;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r  <= {CNT_W{1'b0}};
      filt_r <= RawIn;
    end else begin
      cnt_r  <= cnt_r + CNT_W'(1);
      filt_r <= filt_r;
    end
  end

  assign FiltOut = filt_r;

endmodule

// File: rtl/car_warning_ctrl.sv
// Car door/seat-belt warning controller: debounced switches feed the warning
// equation, and a Moore FSM sequences timed chimes with ack / count based mute.
module car_warning_ctrl
  import car_warning_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int CHIME_ON     = 8,
  parameter int CHIME_OFF    = 8,
  parameter int MAX_CHIMES   = 6,
  parameter int CNT_W        = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic DoorClose,
  input  logic Ignition,
  input  logic SeatBelt,
  input  logic Ack,
  output logic Alarm,
  output logic WarnLamp,
  output logic Muted
);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(CHIME_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(CHIME_OFF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CHIMES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic door_s;
  logic ign_s;
  logic belt_s;
  logic warn_s;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] timer_r;
  logic [CNT_W-1:0] timer_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  input_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .CNT_W        (CNT_W),
    .RST_VAL      (DOOR_RST)
  ) u_db_door (
    .Clk     (Clk),
    .Reset   (Reset),
    .RawIn   (DoorClose),
    .FiltOut (door_s)
  );

  input_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .CNT_W        (CNT_W),
    .RST_VAL      (IGN_RST)
  ) u_db_ign (
    .Clk     (Clk),
    .Reset   (Reset),
    .RawIn   (Ignition),
    .FiltOut (ign_s)
  );

  input_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .CNT_W        (CNT_W),
    .RST_VAL      (BELT_RST)
  ) u_db_belt (
    .Clk     (Clk),
    .Reset   (Reset),
    .RawIn   (SeatBelt),
    .FiltOut (belt_s)
  );

  // Warning is a pure function of the filtered flops, so it moves on their edge
  assign warn_s = warn_eq(door_s, ign_s, belt_s);

  // State, chime timer and chime counter registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      timer_r <= CNT_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      timer_r <= timer_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Next-state logic; a dropped warning overrides ack and timer expiry
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = timer_r;
    count_nxt_s = count_r;
    if (!warn_s) begin
      state_nxt_s = ST_IDLE;
      timer_nxt_s = CNT_ZERO;
      count_nxt_s = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_CHIME_ON;
          timer_nxt_s = CNT_ZERO;
        end
        ST_CHIME_ON: begin
          if (Ack) begin
            state_nxt_s = ST_MUTED;
            timer_nxt_s = CNT_ZERO;
          end else if (timer_r == ON_LAST) begin
            state_nxt_s = ST_CHIME_OFF;
            timer_nxt_s = CNT_ZERO;
            count_nxt_s = sat_inc(count_r);
          end else begin
            timer_nxt_s = sat_inc(timer_r);
          end
        end
        ST_CHIME_OFF: begin
          if (Ack) begin
            state_nxt_s = ST_MUTED;
            timer_nxt_s = CNT_ZERO;
          end else if (timer_r == OFF_LAST) begin
            timer_nxt_s = CNT_ZERO;
            if (count_r == CNT_MAX) begin
              state_nxt_s = ST_MUTED;
            end else begin
              state_nxt_s = ST_CHIME_ON;
            end
          end else begin
            timer_nxt_s = sat_inc(timer_r);
          end
        end
        ST_MUTED: begin
          state_nxt_s = ST_MUTED;
        end
        default: begin
          // Illegal one-hot pattern: recover to a silent, re-armable state
          state_nxt_s = ST_IDLE;
          timer_nxt_s = CNT_ZERO;
          count_nxt_s = CNT_ZERO;
        end
      endcase
    end
  end

  // Moore outputs taken straight from state flop bits
  always_comb begin
    Alarm    = state_r[IDX_CHIME_ON];
    Muted    = state_r[IDX_MUTED];
    WarnLamp = warn_s;
  end

endmodule

// File: tb/tb_car_warning_ctrl.sv
// Directed self-checking bench for car_warning_ctrl with
// DEBOUNCE_CYC=4, CHIME_ON=8, CHIME_OFF=8, MAX_CHIMES=3.
module tb_car_warning_ctrl;

  logic Clk = 1'b0;
  logic Reset;
  logic DoorClose;
  logic Ignition;
  logic SeatBelt;
  logic Ack;
  logic Alarm;
  logic WarnLamp;
  logic Muted;

  int n_checks = 0;
  int n_fail   = 0;

  car_warning_ctrl #(
    .DEBOUNCE_CYC (4),
    .CHIME_ON     (8),
    .CHIME_OFF    (8),
    .MAX_CHIMES   (3),
    .CNT_W        (8)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .DoorClose (DoorClose),
    .Ignition  (Ignition),
    .SeatBelt  (SeatBelt),
    .Ack       (Ack),
    .Alarm     (Alarm),
    .WarnLamp  (WarnLamp),
    .Muted     (Muted)
  );

  always #5 Clk = ~Clk;

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(input logic door, input logic ign, input logic belt);
    Reset = 1'b1; DoorClose = door; Ignition = ign; SeatBelt = belt; Ack = 1'b0;
    step(); step();
    Reset = 1'b0;
  endtask

  // Chime pattern after warn-creating change sampled at edge 1
  function automatic logic exp_alarm(input int e);
    return (e >= 5) && (e < 53) && (((e - 5) % 16) < 8);
  endfunction

  task automatic test_reset();
    Reset = 1'b1; Ignition = 1'b1; DoorClose = 1'b0; SeatBelt = 1'b1; Ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if ({Alarm, WarnLamp, Muted} !== 3'b000) begin
        $display("FAIL reset_hold cyc %0d: got A/L/M=%b%b%b want 000", i, Alarm, WarnLamp, Muted);
        n_fail++;
      end
    end
    Reset = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      n_checks++;
      if (WarnLamp !== (e >= 4) || Alarm !== (e >= 5) || Muted !== 1'b0) begin
        $display("FAIL reset_release edge %0d: got L=%b A=%b M=%b want L=%b A=%b M=0",
                 e, WarnLamp, Alarm, Muted, e >= 4, e >= 5);
        n_fail++;
      end
    end
  endtask

  task automatic test_glitch();
    do_reset(1'b1, 1'b1, 1'b1);
    repeat (6) step();
    SeatBelt = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      step();
      if (e == 3) SeatBelt = 1'b1;
      n_checks++;
      if (WarnLamp !== 1'b0 || Alarm !== 1'b0) begin
        $display("FAIL glitch edge %0d: got L=%b A=%b want 0 0", e, WarnLamp, Alarm);
        n_fail++;
      end
    end
  endtask

  task automatic test_chime_seq();
    do_reset(1'b1, 1'b1, 1'b1);
    repeat (6) step();
    SeatBelt = 1'b0;
    for (int e = 1; e <= 70; e++) begin
      step();
      n_checks++;
      if (Alarm !== exp_alarm(e) || Muted !== (e >= 53) || WarnLamp !== (e >= 4)) begin
        $display("FAIL chime_seq edge %0d: got A=%b M=%b L=%b want A=%b M=%b L=%b",
                 e, Alarm, Muted, WarnLamp, exp_alarm(e), e >= 53, e >= 4);
        n_fail++;
      end
    end
    // A new cause while muted must not re-arm
    DoorClose = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      n_checks++;
      if (Alarm !== 1'b0 || Muted !== 1'b1 || WarnLamp !== 1'b1) begin
        $display("FAIL muted_new_cause edge %0d: got A=%b M=%b L=%b want 0 1 1", e, Alarm, Muted, WarnLamp);
        n_fail++;
      end
    end
  endtask

  task automatic test_ack();
    do_reset(1'b1, 1'b1, 1'b1);
    repeat (6) step();
    SeatBelt = 1'b0;
    repeat (24) step();
    n_checks++;
    if (Alarm !== 1'b1) begin
      $display("FAIL ack_pre edge 24: got A=%b want 1", Alarm);
      n_fail++;
    end
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    n_checks++;
    if (Alarm !== 1'b0 || Muted !== 1'b1) begin
      $display("FAIL ack_mute: got A=%b M=%b want 0 1", Alarm, Muted);
      n_fail++;
    end
    SeatBelt = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      n_checks++;
      if (Muted !== (e < 5) || WarnLamp !== (e < 4) || Alarm !== 1'b0) begin
        $display("FAIL ack_clear edge %0d: got M=%b L=%b A=%b want M=%b L=%b A=0",
                 e, Muted, WarnLamp, Alarm, e < 5, e < 4);
        n_fail++;
      end
    end
    SeatBelt = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      step();
      n_checks++;
      if (Alarm !== exp_alarm(e) || Muted !== (e >= 53)) begin
        $display("FAIL ack_rearm edge %0d: got A=%b M=%b want A=%b M=%b", e, Alarm, Muted, exp_alarm(e), e >= 53);
        n_fail++;
      end
    end
  endtask

  task automatic test_ack_at_rise();
    do_reset(1'b1, 1'b1, 1'b1);
    repeat (6) step();
    Ack = 1'b1;
    SeatBelt = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      n_checks++;
      if (Alarm !== (e == 5) || Muted !== (e >= 6)) begin
        $display("FAIL ack_at_rise edge %0d: got A=%b M=%b want A=%b M=%b", e, Alarm, Muted, e == 5, e >= 6);
        n_fail++;
      end
    end
    Ack = 1'b0;
  endtask

  task automatic test_warn_drop();
    do_reset(1'b1, 1'b1, 1'b1);
    repeat (6) step();
    SeatBelt = 1'b0;
    repeat (5) step();
    SeatBelt = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      // Ack coincides with the drop reaching the FSM; IDLE must win
      if (e == 4) Ack = 1'b1;
      if (e == 5) Ack = 1'b0;
      n_checks++;
      if (Alarm !== (e < 5) || Muted !== 1'b0 || WarnLamp !== (e < 4)) begin
        $display("FAIL warn_drop edge %0d: got A=%b M=%b L=%b want A=%b M=0 L=%b",
                 e, Alarm, Muted, WarnLamp, e < 5, e < 4);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1, 1'b1, 1'b1);
    repeat (6) step();
    SeatBelt = 1'b0;
    repeat (32) step();
    n_checks++;
    if (Alarm !== 1'b0 || Muted !== 1'b0 || WarnLamp !== 1'b1) begin
      $display("FAIL reset_mid_pre: got A=%b M=%b L=%b want 0 0 1", Alarm, Muted, WarnLamp);
      n_fail++;
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    n_checks++;
    if ({Alarm, WarnLamp, Muted} !== 3'b000) begin
      $display("FAIL reset_mid_pulse: got A/L/M=%b%b%b want 000", Alarm, WarnLamp, Muted);
      n_fail++;
    end
    for (int e = 1; e <= 60; e++) begin
      step();
      n_checks++;
      if (Alarm !== exp_alarm(e) || Muted !== (e >= 53) || WarnLamp !== (e >= 4)) begin
        $display("FAIL reset_mid_rerun edge %0d: got A=%b M=%b L=%b want A=%b M=%b L=%b",
                 e, Alarm, Muted, WarnLamp, exp_alarm(e), e >= 53, e >= 4);
        n_fail++;
      end
    end
  endtask

  initial begin
    Reset = 1'b1; DoorClose = 1'b1; Ignition = 1'b0; SeatBelt = 1'b1; Ack = 1'b0;
    test_reset();
    test_glitch();
    test_chime_seq();
    test_ack();
    test_ack_at_rise();
    test_warn_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
